wb_mlane: RTL
=============

WB_MLANE -- requirements
Module: wb_mlane

Interface
REQ-001 Parameter LANES, default 2, meaning retiring lanes per cycle, legal 1..2.
REQ-002 Parameter AW, default 5, meaning register-address width.
REQ-003 Parameter DW, default 32, meaning register-data width.
REQ-004 Parameter DBG_DEPTH, default 4, meaning trace FIFO entries, power of 2, >= 2*LANES.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 flush  in  1  discard the current writeback contents.
REQ-008 stall  in  8  pipeline stall bus; bit 6 = this stage, bit 7 = downstream.
REQ-009 mem_to_wb_bus  in  66+LANES*(34+AW+DW)  {hilo_bus_i[65:0], lane LANES-1 .. lane 0}; each lane {valid, pc[31:0], we, waddr, wdata}.
REQ-010 rf_we  out  LANES  register-file write enable per lane.
REQ-011 rf_waddr  out  LANES*AW  write address per lane, lane 0 in LSBs.
REQ-012 rf_wdata  out  LANES*DW  write data per lane, lane 0 in LSBs.
REQ-013 hilo_bus  out  66  registered HI/LO write bundle, passed opaquely.
REQ-014 debug_wb_pc  out  32  trace PC, one retired lane per cycle.
REQ-015 debug_wb_rf_wen  out  4  trace write enable, {4{we}}.
REQ-016 debug_wb_rf_wnum  out  AW  trace write address.
REQ-017 debug_wb_rf_wdata  out  DW  trace write data.
REQ-018 stallreq_wb  out  1  combinational request to stall the pipeline when the trace FIFO cannot accept a full bundle.

Function
REQ-019 Commit register update priority per edge SHALL be: flush -> bubble; stall[6]=1 and stall[7]=0 -> bubble; stall[6]=0 -> load; otherwise hold.
REQ-020 A bubble SHALL clear all lane fields and hilo_bus to 0.
REQ-021 Load latency SHALL be one cycle: bus value at edge N is visible on rf_* and hilo_bus after edge N.
REQ-022 rf_we[i] SHALL be registered valid_i & we_i & (waddr_i != 0).
REQ-023 If both lanes load with write enable to the same nonzero waddr, lane 0's rf_we SHALL be forced 0 (lane 1 is younger and wins).
REQ-024 On a load, every lane with valid=1 SHALL be pushed into the trace FIFO in lane order (lane 0 first), storing pc, we&(waddr!=0), waddr, wdata; invalid lanes are not pushed.
REQ-025 Each edge, if the FIFO count before the edge is nonzero, the head SHALL pop into the debug_* registers; otherwise debug_* SHALL clear to 0.
REQ-026 Trace latency: a lone lane loaded at edge N SHALL appear on debug_* after edge N+1.
REQ-027 Push and pop in the same edge SHALL be allowed: count_next = count + pushes - pop.
REQ-028 Read and write pointers SHALL wrap modulo DBG_DEPTH.
REQ-029 stallreq_wb SHALL equal (count > DBG_DEPTH - LANES).
REQ-030 Overflow SHALL be impossible when the stall controller honours stallreq_wb; any push beyond capacity SHALL be dropped, and count SHALL saturate at DBG_DEPTH.
REQ-031 flush SHALL NOT clear the trace FIFO; already-retired entries still drain.

Reset
REQ-032 While rst=0, the block SHALL immediately clear to 0 all commit registers, hilo_bus, debug_* outputs, FIFO pointers and count.
REQ-033 After reset, stallreq_wb SHALL be 0.
REQ-034 Reset asserted mid-drain SHALL discard all pending trace entries.

Configuration
REQ-035 Macro WB_DEBUG_TRACE_EN: when defined, the trace FIFO and the debug_* behaviour of REQ-024..031 SHALL be built.
REQ-036 When WB_DEBUG_TRACE_EN is undefined, no FIFO SHALL be built, debug_* SHALL be tied 0, and stallreq_wb SHALL be tied 0.

Verification
REQ-037 Single lane, LANES=2: load lane0 {valid=1, pc=0xBFC00000, we=1, waddr=3, wdata=0x11} -> rf_we=01 after edge N; debug_wb_pc=0xBFC00000, wen=4'hF after edge N+1.
REQ-038 Dual retire: lanes pc 0x100/0x104, waddr 4/5 -> both rf_we set; debug shows 0x100 then 0x104 on consecutive cycles.
REQ-039 Write conflict: both lanes write waddr=7, wdata 0xA/0xB -> rf_we=10; the trace still shows both entries.
REQ-040 FIFO fill: dual retire every cycle with stall ignored, DBG_DEPTH=4 -> stallreq_wb=1 once count=3; count never exceeds 4.
REQ-041 Bubble/flush: stall=8'b0100_0000 -> rf_we=0, hilo_bus=0; flush with 3 FIFO entries -> those 3 entries still drain over 3 cycles.
REQ-042 Async reset mid-drain: rst=0 between edges -> debug_wb_pc=0 and stallreq_wb=0 immediately, with no further entries traced.

Source files
------------

// File: rtl/wb_mlane_if.sv
// wb_mlane_if: writeback-stage signal bundle between the pipeline (master) and wb_mlane (slave).
interface wb_mlane_if #(parameter int LANES = 2, parameter int AW = 5, parameter int DW = 32);
  localparam int BW = 66 + LANES * (34 + AW + DW);
  logic                flush;
  logic [7:0]          stall;
  logic [BW-1:0]       mem_to_wb_bus;
  logic [LANES-1:0]    rf_we;
  logic [LANES*AW-1:0] rf_waddr;
  logic [LANES*DW-1:0] rf_wdata;
  logic [65:0]         hilo_bus;
  logic [31:0]         debug_wb_pc;
  logic [3:0]          debug_wb_rf_wen;
  logic [AW-1:0]       debug_wb_rf_wnum;
  logic [DW-1:0]       debug_wb_rf_wdata;
  logic                stallreq_wb;
  modport master (
    output flush, stall, mem_to_wb_bus,
    input  rf_we, rf_waddr, rf_wdata, hilo_bus, debug_wb_pc, debug_wb_rf_wen,
           debug_wb_rf_wnum, debug_wb_rf_wdata, stallreq_wb
  );
  modport slave (
    input  flush, stall, mem_to_wb_bus,
    output rf_we, rf_waddr, rf_wdata, hilo_bus, debug_wb_pc, debug_wb_rf_wen,
           debug_wb_rf_wnum, debug_wb_rf_wdata, stallreq_wb
  );
endinterface

// File: rtl/wb_mlane.sv
// wb_mlane: multi-lane writeback commit register with an optional retire-trace FIFO.
// Define WB_DEBUG_TRACE_EN to build the trace FIFO; otherwise debug_* and stallreq_wb are tied 0.
module wb_mlane #(
  parameter int LANES     = 2,
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int DBG_DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  wb_mlane_if.slave  wb
);
  localparam int LW = 34 + AW + DW;
  logic [LANES-1:0]          w_valid, w_lwe, w_we, w_conf;
  logic [LANES-1:0][31:0]    w_pc;
  logic [LANES-1:0][AW-1:0]  w_waddr;
  logic [LANES-1:0][DW-1:0]  w_wdata;
  logic                      w_bubble, w_load;
  logic [LANES-1:0]          r_we;
  logic [LANES-1:0][AW-1:0]  r_waddr;
  logic [LANES-1:0][DW-1:0]  r_wdata;
  logic [65:0]               r_hilo;
  assign w_bubble = wb.flush | (wb.stall[6] & ~wb.stall[7]);
  assign w_load   = ~wb.flush & ~wb.stall[6];
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign {w_valid[i], w_pc[i], w_lwe[i], w_waddr[i], w_wdata[i]} = wb.mem_to_wb_bus[i*LW +: LW];
    assign w_we[i] = w_valid[i] & w_lwe[i] & (|w_waddr[i]);
  end
  // lane 1 is younger, so on a same-register collision lane 0's write is squashed
  if (LANES == 2) begin : g_conf
    assign w_conf = {1'b0, w_we[0] & w_we[1] & (w_waddr[0] == w_waddr[1])};
  end else begin : g_noconf
    assign w_conf = '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_we    <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_hilo  <= '0;
    end else if (w_bubble | w_load) begin
      r_we    <= w_load ? w_we & ~w_conf : '0;
      r_waddr <= w_load ? w_waddr : '0;
      r_wdata <= w_load ? w_wdata : '0;
      r_hilo  <= w_load ? wb.mem_to_wb_bus[LANES*LW +: 66] : '0;
    end
  assign wb.rf_we    = r_we;
  assign wb.rf_waddr = r_waddr;
  assign wb.rf_wdata = r_wdata;
  assign wb.hilo_bus = r_hilo;
`ifdef WB_DEBUG_TRACE_EN
  localparam int PW = $clog2(DBG_DEPTH);
  localparam int CW = $clog2(DBG_DEPTH + 1);
  localparam int EW = 33 + AW + DW;
  logic [EW-1:0]             r_mem [DBG_DEPTH];
  logic [PW-1:0]             r_wp, r_rp;
  logic [CW-1:0]             r_cnt, w_n, w_room;
  logic [LANES-1:0]          w_acc;
  logic [LANES-1:0][PW-1:0]  w_slot;
  logic                      w_pop, r_dbg_we, w_unused;
  logic [31:0]               r_dbg_pc;
  logic [AW-1:0]             r_dbg_wnum;
  logic [DW-1:0]             r_dbg_wdata;
  assign w_unused = ^wb.stall[5:0];
  assign w_pop    = |r_cnt;
  // the slot being popped this edge is free for a push in the same edge
  assign w_room   = CW'(DBG_DEPTH) - r_cnt + CW'(w_pop);
  always_comb begin
    w_n    = '0;
    w_acc  = '0;
    w_slot = '0;
    for (int i = 0; i < LANES; i++) begin
      w_slot[i] = r_wp + PW'(w_n);
      w_acc[i]  = w_load & w_valid[i] & (w_n < w_room);
      w_n       = w_n + CW'(w_acc[i]);
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < LANES; i++)
      if (w_acc[i]) r_mem[w_slot[i]] <= {w_pc[i], w_we[i], w_waddr[i], w_wdata[i]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_dbg_pc    <= '0;
      r_dbg_we    <= 1'b0;
      r_dbg_wnum  <= '0;
      r_dbg_wdata <= '0;
    end else begin
      r_wp  <= r_wp + PW'(w_n);
      r_rp  <= r_rp + PW'(w_pop);
      r_cnt <= r_cnt + w_n - CW'(w_pop);
      {r_dbg_pc, r_dbg_we, r_dbg_wnum, r_dbg_wdata} <= w_pop ? r_mem[r_rp] : '0;
    end
  assign wb.debug_wb_pc       = r_dbg_pc;
  assign wb.debug_wb_rf_wen   = {4{r_dbg_we}};
  assign wb.debug_wb_rf_wnum  = r_dbg_wnum;
  assign wb.debug_wb_rf_wdata = r_dbg_wdata;
  assign wb.stallreq_wb       = r_cnt > CW'(DBG_DEPTH - LANES);
`else
  logic w_unused;
  assign w_unused = ^{w_pc, wb.stall[5:0]};
  assign wb.debug_wb_pc       = '0;
  assign wb.debug_wb_rf_wen   = '0;
  assign wb.debug_wb_rf_wnum  = '0;
  assign wb.debug_wb_rf_wdata = '0;
  assign wb.stallreq_wb       = 1'b0;
`endif
endmodule
